interrupt_unit: RTL and testbench

- Interrupt front end: collects peripheral interrupt lines and a non-maskable source, synchronises and prioritises them, and masks them.
- Drives the INT, NMI and INTD inputs of the multicycle controller.
- Consumes the controller's isInterrupted/INA acknowledge, and exposes the serviced vector to the datapath for handler address selection.
- Tracks in-service state so that requests do not re-fire until software issues end-of-interrupt.

---
 rtl/interrupt_unit.sv | 215 +++++++++++++++++++++
 tb/tb_interrupt_unit.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_unit.sv
// -----------------------------------------------------------------------------
// interrupt_unit
//
// Interrupt front end for the multicycle controller. Peripheral request lines
// and a non-maskable source are synchronised, latched as pending events,
// masked, prioritised (line 0 highest) and presented to the controller as
// registered INT / NMI / INTD. The controller's acknowledge selects which
// source is taken; the serviced line index is held on `vector` until software
// issues an end-of-interrupt.
//
// Build option:
//   INTC_LEVEL_IRQ_EN  undefined (default): a request line is edge-triggered,
//                      and a line held high produces a single request.
//                      defined: pending tracks the synchronised line level
//                      every cycle and is not cleared by an acknowledge, so
//                      a line still high after eoi requests again.
//                      The NMI path is edge-triggered in both builds.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   irq_in          maskable request lines, asynchronous, active high
//   nmi_in          non-maskable request, asynchronous, active high
//   mask_we         load mask register from mask_wdata (1 = line masked)
//   ien_set/ien_clr set / clear global enable (clear wins)
//   ack             controller isInterrupted level; its 0->1 edge is used
//   ack_ina         sampled with the ack edge: 1 = maskable, 0 = NMI taken
//   eoi             single-cycle end-of-interrupt pulse
//   INT, NMI, INTD  registered requests / interrupts-disabled to controller
//   vector          index of the maskable line being serviced
//   pending         latched pending request bits
//   in_service      any interrupt currently in service
//   fsm_state       current service state (IDLE=0, SERV_INT=1,
//                   SERV_NMI=2, SERV_NMI_NEST=3)
//
// Handshake: INT and NMI are requests that stay asserted while their source
// is pending and serviceable. The controller accepts a request with the
// rising edge of ack; ack_ina, sampled at that same edge, names the accepted
// source. An accepted request drops, and INTD rises, at the edge that
// registers the acceptance. An ack edge naming a source with nothing pending
// is ignored.
// -----------------------------------------------------------------------------
module interrupt_unit #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               ien_set,
  input  logic               ien_clr,
  input  logic               ack,
  input  logic               ack_ina,
  input  logic               eoi,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    SERV_INT      = 2'd1,
    SERV_NMI      = 2'd2,
    SERV_NMI_NEST = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [NUM_IRQ-1:0] irq_s1, irq_s2;
  logic               nmi_s1, nmi_s2, nmi_s2_d;
  logic [NUM_IRQ-1:0] mask;
  logic               ien;
  logic               ack_q;
  logic               nmi_pend;

  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [VEC_W-1:0]   winner;
  logic               found;
  logic               ack_edge;
  logic               take_int;
  logic               take_nmi;
  logic               nmi_rise;
  logic               ien_nxt;

  assign cand     = pending & ~mask;
  assign ack_edge = ack & ~ack_q;
  assign nmi_rise = nmi_s2 & ~nmi_s2_d;
  assign ien_nxt  = ien_clr ? 1'b0 : (ien_set ? 1'b1 : ien);

  assign in_service = (state != IDLE);
  assign fsm_state  = state;

  // Lowest set index of cand wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand[i] && !found) begin
        winner = VEC_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Next-state logic. An NMI acknowledge during maskable service takes
  // precedence over an eoi arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    take_int  = 1'b0;
    take_nmi  = 1'b0;
    case (state)
      IDLE: begin
        if (ack_edge && ack_ina && found) begin
          take_int  = 1'b1;
          state_nxt = SERV_INT;
        end else if (ack_edge && !ack_ina && nmi_pend) begin
          take_nmi  = 1'b1;
          state_nxt = SERV_NMI;
        end
      end
      SERV_INT: begin
        if (ack_edge && !ack_ina && nmi_pend) begin
          take_nmi  = 1'b1;
          state_nxt = SERV_NMI_NEST;
        end else if (eoi) begin
          state_nxt = IDLE;
        end
      end
      SERV_NMI: begin
        if (eoi) state_nxt = IDLE;
      end
      SERV_NMI_NEST: begin
        // Return to the interrupted maskable handler; vector is untouched.
        if (eoi) state_nxt = SERV_INT;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef INTC_LEVEL_IRQ_EN
  // Level mode: pending mirrors the synchronised lines; acknowledge does not
  // clear it, the state machine alone keeps INT quiet during service.
  assign pending_nxt = irq_s2;
`else
  logic [NUM_IRQ-1:0] irq_s2_d;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] clr_vec;

  assign irq_rise = irq_s2 & ~irq_s2_d;

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = take_int && (winner == VEC_W'(i));
    end
  end

  // Clear first, then set: a new rise in the acknowledge cycle is kept.
  assign pending_nxt = (pending & ~clr_vec) | irq_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_s2_d <= '0;
    else        irq_s2_d <= irq_s2;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1   <= '0;
      irq_s2   <= '0;
      nmi_s1   <= 1'b0;
      nmi_s2   <= 1'b0;
      nmi_s2_d <= 1'b0;
      mask     <= '1;
      ien      <= 1'b0;
      ack_q    <= 1'b0;
      nmi_pend <= 1'b0;
      pending  <= '0;
      vector   <= '0;
      INT      <= 1'b0;
      NMI      <= 1'b0;
      INTD     <= 1'b1;
    end else begin
      irq_s1   <= irq_in;
      irq_s2   <= irq_s1;
      nmi_s1   <= nmi_in;
      nmi_s2   <= nmi_s1;
      nmi_s2_d <= nmi_s2;
      ack_q    <= ack;
      ien      <= ien_nxt;
      if (mask_we) mask <= mask_wdata;
      pending  <= pending_nxt;
      nmi_pend <= (nmi_pend & ~take_nmi) | nmi_rise;
      if (take_int) vector <= winner;
      // Outputs are evaluated from the current state; an acceptance in this
      // cycle drops the request and raises INTD at the same edge.
      INT  <= ien & (|cand) & (state == IDLE) & ~take_int & ~take_nmi;
      NMI  <= nmi_pend & (state != SERV_NMI) & (state != SERV_NMI_NEST) & ~take_nmi;
      INTD <= ~ien | (state != IDLE) | take_int | take_nmi;
    end
  end

endmodule

// File: tb/tb_interrupt_unit.sv
// -----------------------------------------------------------------------------
// tb_interrupt_unit
//
// Directed bench for interrupt_unit. A behavioural model tracks sampled line
// history, pending events and a stack of in-service sources; a compare
// process checks every DUT output against it on each falling edge. Directed
// sequences add hand-computed literal checks and an expected-vector queue.
// -----------------------------------------------------------------------------
module tb_interrupt_unit;

  localparam int NUM_IRQ = 8;
  localparam int VEC_W   = 3;

  logic               clk;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq_in;
  logic               nmi_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               ien_set;
  logic               ien_clr;
  logic               ack;
  logic               ack_ina;
  logic               eoi;
  logic               INT;
  logic               NMI;
  logic               INTD;
  logic [VEC_W-1:0]   vector;
  logic [NUM_IRQ-1:0] pending;
  logic               in_service;
  logic [1:0]         fsm_state;

  interrupt_unit #(.NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .nmi_in     (nmi_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ien_set    (ien_set),
    .ien_clr    (ien_clr),
    .ack        (ack),
    .ack_ina    (ack_ina),
    .eoi        (eoi),
    .INT        (INT),
    .NMI        (NMI),
    .INTD       (INTD),
    .vector     (vector),
    .pending    (pending),
    .in_service (in_service),
    .fsm_state  (fsm_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ bookkeeping
  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;
  logic [VEC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_vec(input string name);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected-vector queue empty", name);
    end else begin
      check(name, 32'(vector), 32'(exp_q.pop_front()));
    end
  endtask

  // ------------------------------------------------------------------ model
  // Line history: h[0] = last sample, h[1] = sample two edges back, etc.
  logic [NUM_IRQ-1:0] m_irq_h[3];
  logic               m_nmi_h[3];
  logic [NUM_IRQ-1:0] m_pend;
  logic [NUM_IRQ-1:0] m_mask;
  logic               m_nmi_pend;
  logic               m_ien;
  logic               m_ack_prev;
  int                 m_stk[$];     // in-service sources, -1 = NMI
  logic               m_int, m_nmi_o, m_intd;
  logic [VEC_W-1:0]   m_vec;
  logic [1:0]         m_state;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_irq_h[k] = '0;
        m_nmi_h[k] = 1'b0;
      end
      m_pend = '0; m_mask = '1; m_nmi_pend = 1'b0; m_ien = 1'b0;
      m_ack_prev = 1'b0; m_stk.delete();
      m_int = 1'b0; m_nmi_o = 1'b0; m_intd = 1'b1; m_vec = '0; m_state = 2'd0;
    end else begin
      logic [NUM_IRQ-1:0] cand;
      int  low;
      logic edge_a, t_int, t_nmi, done, nmi_top;
      cand = m_pend & ~m_mask;
      low = -1;
      for (int i = 0; i < NUM_IRQ; i++) if (cand[i] && low < 0) low = i;
      edge_a  = ack && !m_ack_prev;
      nmi_top = (m_stk.size() > 0) && (m_stk[$] < 0);
      t_int = edge_a && ack_ina && (m_stk.size() == 0) && (low >= 0);
      t_nmi = edge_a && !ack_ina && m_nmi_pend &&
              ((m_stk.size() == 0) || (m_stk.size() == 1 && m_stk[$] >= 0));
      done  = eoi && (m_stk.size() > 0) && !t_nmi;
      m_int   = m_ien && (cand != 0) && (m_stk.size() == 0) && !t_int && !t_nmi;
      m_nmi_o = m_nmi_pend && !nmi_top && !t_nmi;
      m_intd  = !m_ien || (m_stk.size() != 0) || t_int || t_nmi;
      if (t_int) begin
        m_stk.push_back(low);
        m_vec = VEC_W'(low);
        m_pend[low] = 1'b0;
      end
      if (t_nmi) begin
        m_stk.push_back(-1);
        m_nmi_pend = 1'b0;
      end
      if (done) void'(m_stk.pop_back());
`ifdef INTC_LEVEL_IRQ_EN
      m_pend = m_irq_h[1];
`else
      m_pend = m_pend | (m_irq_h[1] & ~m_irq_h[2]);
`endif
      m_nmi_pend = m_nmi_pend | (m_nmi_h[1] & ~m_nmi_h[2]);
      m_irq_h[2] = m_irq_h[1]; m_irq_h[1] = m_irq_h[0]; m_irq_h[0] = irq_in;
      m_nmi_h[2] = m_nmi_h[1]; m_nmi_h[1] = m_nmi_h[0]; m_nmi_h[0] = nmi_in;
      if (mask_we) m_mask = mask_wdata;
      m_ien = ien_clr ? 1'b0 : (ien_set ? 1'b1 : m_ien);
      m_ack_prev = ack;
      if (m_stk.size() == 0)     m_state = 2'd0;
      else if (m_stk[$] >= 0)    m_state = 2'd1;
      else if (m_stk.size() == 1) m_state = 2'd2;
      else                       m_state = 2'd3;
    end
  end

  // ---------------------------------------------------------- compare
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_INT",        32'(INT),        32'(m_int));
      check("cyc_NMI",        32'(NMI),        32'(m_nmi_o));
      check("cyc_INTD",       32'(INTD),       32'(m_intd));
      check("cyc_vector",     32'(vector),     32'(m_vec));
      check("cyc_pending",    32'(pending),    32'(m_pend));
      check("cyc_in_service", 32'(in_service), 32'(m_stk.size() != 0));
      check("cyc_state",      32'(fsm_state),  32'(m_state));
    end
  end

  // ---------------------------------------------------------- drivers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_irq(input logic [NUM_IRQ-1:0] v);
    irq_in = v;
    tick(1);
    irq_in = '0;
  endtask

  task automatic pulse_nmi();
    nmi_in = 1'b1;
    tick(1);
    nmi_in = 1'b0;
  endtask

  task automatic do_ack(input logic ina);
    ack = 1'b1;
    ack_ina = ina;
    tick(1);
    ack = 1'b0;
    ack_ina = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  task automatic arm();
    ien_set = 1'b1;
    mask_we = 1'b1;
    mask_wdata = '0;
    tick(1);
    ien_set = 1'b0;
    mask_we = 1'b0;
    tick(1);
    check("arm_INTD", 32'(INTD), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_INT"},  32'(INT),        32'd0);
    check({tag, "_NMI"},  32'(NMI),        32'd0);
    check({tag, "_INTD"}, 32'(INTD),       32'd1);
    check({tag, "_vec"},  32'(vector),     32'd0);
    check({tag, "_pend"}, 32'(pending),    32'd0);
    check({tag, "_isv"},  32'(in_service), 32'd0);
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    rst_n = 1'b0;
    irq_in = '0; nmi_in = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    ien_set = 1'b0; ien_clr = 1'b0; ack = 1'b0; ack_ina = 1'b0; eoi = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    arm();

`ifndef INTC_LEVEL_IRQ_EN
    // Single line: 3-edge latency, then acknowledge.
    pulse_irq(8'h20);
    check("t1_int_e1", 32'(INT), 32'd0);
    tick(1);
    check("t1_int_e2", 32'(INT), 32'd0);
    tick(1);
    check("t1_pend", 32'(pending), 32'h20);
    check("t1_int_e3", 32'(INT), 32'd0);
    tick(1);
    check("t1_int", 32'(INT), 32'd1);
    exp_q.push_back(3'd5);
    do_ack(1'b1);
    check_vec("t1_vec");
    check("t1_intd", 32'(INTD), 32'd1);
    check("t1_int_off", 32'(INT), 32'd0);
    check("t1_pend_clr", 32'(pending), 32'h00);
    do_eoi();
    check("t1_isv", 32'(in_service), 32'd0);
    tick(1);
    check("t1_intd_off", 32'(INTD), 32'd0);

    // Two lines at once: priority, then re-request after eoi.
    pulse_irq(8'h44);
    tick(3);
    check("t2_pend", 32'(pending), 32'h44);
    exp_q.push_back(3'd2);
    do_ack(1'b1);
    check_vec("t2_vec_a");
    check("t2_pend_a", 32'(pending), 32'h40);
    do_eoi();
    check("t2_int_hold", 32'(INT), 32'd0);
    tick(1);
    check("t2_int_re", 32'(INT), 32'd1);
    exp_q.push_back(3'd6);
    do_ack(1'b1);
    check_vec("t2_vec_b");
    check("t2_pend_b", 32'(pending), 32'h00);
    do_eoi();
    tick(1);

    // Masked line stays pending and fires once unmasked.
    mask_we = 1'b1; mask_wdata = 8'hFF;
    tick(1);
    mask_we = 1'b0;
    pulse_irq(8'h08);
    tick(3);
    check("t3_int_masked", 32'(INT), 32'd0);
    check("t3_pend", 32'(pending), 32'h08);
    mask_we = 1'b1; mask_wdata = 8'h00;
    tick(1);
    mask_we = 1'b0;
    check("t3_int_e1", 32'(INT), 32'd0);
    tick(1);
    check("t3_int_e2", 32'(INT), 32'd1);
    exp_q.push_back(3'd3);
    do_ack(1'b1);
    check_vec("t3_vec");
    do_eoi();
    tick(1);

    // NMI nested inside maskable service.
    pulse_irq(8'h10);
    tick(3);
    exp_q.push_back(3'd4);
    do_ack(1'b1);
    check_vec("t4_vec");
    pulse_nmi();
    tick(2);
    check("t4_nmi_e2", 32'(NMI), 32'd0);
    tick(1);
    check("t4_nmi", 32'(NMI), 32'd1);
    do_ack(1'b0);
    check("t4_nmi_off", 32'(NMI), 32'd0);
    check("t4_nest", 32'(fsm_state), 32'd3);
    check("t4_vec_nest", 32'(vector), 32'd4);
    do_eoi();
    check("t4_back_int", 32'(fsm_state), 32'd1);
    check("t4_vec_kept", 32'(vector), 32'd4);
    check("t4_intd_serv", 32'(INTD), 32'd1);
    do_eoi();
    check("t4_idle", 32'(fsm_state), 32'd0);
    tick(1);
    check("t4_intd_idle", 32'(INTD), 32'd0);

    // NMI taken from idle.
    pulse_nmi();
    tick(3);
    check("t5_nmi", 32'(NMI), 32'd1);
    check("t5_intd", 32'(INTD), 32'd0);
    do_ack(1'b0);
    check("t5_state", 32'(fsm_state), 32'd2);
    check("t5_nmi_off", 32'(NMI), 32'd0);
    check("t5_intd_serv", 32'(INTD), 32'd1);
    tick(2);
    check("t5_nmi_quiet", 32'(NMI), 32'd0);
    do_eoi();
    check("t5_idle", 32'(fsm_state), 32'd0);
    tick(1);

    // Acknowledges and eoi with nothing pending are ignored.
    do_ack(1'b1);
    check("t6_ack_int", 32'(fsm_state), 32'd0);
    do_ack(1'b0);
    check("t6_ack_nmi", 32'(fsm_state), 32'd0);
    do_eoi();
    check("t6_eoi", 32'(in_service), 32'd0);
    tick(1);
    check("t6_intd", 32'(INTD), 32'd0);

    // Held line gives a single request in the edge build.
    irq_in = 8'h02;
    tick(4);
    check("t7_int", 32'(INT), 32'd1);
    exp_q.push_back(3'd1);
    do_ack(1'b1);
    check_vec("t7_vec");
    do_eoi();
    tick(3);
    check("t7_no_rereq", 32'(INT), 32'd0);
    check("t7_pend", 32'(pending), 32'h00);
    irq_in = '0;
    tick(1);

    // Global enable gates INT; pending survives.
    ien_clr = 1'b1; ien_set = 1'b1;
    tick(1);
    ien_clr = 1'b0; ien_set = 1'b0;
    check("t8_intd_e1", 32'(INTD), 32'd0);
    tick(1);
    check("t8_intd_e2", 32'(INTD), 32'd1);
    pulse_irq(8'h01);
    tick(3);
    check("t8_int_dis", 32'(INT), 32'd0);
    check("t8_pend", 32'(pending), 32'h01);
    ien_set = 1'b1;
    tick(1);
    ien_set = 1'b0;
    check("t8_int_e1", 32'(INT), 32'd0);
    tick(1);
    check("t8_int_e2", 32'(INT), 32'd1);
    exp_q.push_back(3'd0);
    do_ack(1'b1);
    check_vec("t8_vec");

    // Reset in the middle of service with requests pending.
    pulse_irq(8'h81);
    tick(2);
    check("t9_pend", 32'(pending), 32'h81);
    check("t9_isv", 32'(in_service), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t9_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check("t9_state", 32'(fsm_state), 32'd0);
`else
    // Level build: a held line re-requests after eoi.
    irq_in = 8'h02;
    tick(4);
    check("l1_int", 32'(INT), 32'd1);
    exp_q.push_back(3'd1);
    do_ack(1'b1);
    check_vec("l1_vec_a");
    check("l1_pend_kept", 32'(pending), 32'h02);
    check("l1_int_off", 32'(INT), 32'd0);
    tick(2);
    check("l1_int_serv", 32'(INT), 32'd0);
    do_eoi();
    check("l1_int_e0", 32'(INT), 32'd0);
    tick(1);
    check("l1_int_re", 32'(INT), 32'd1);
    exp_q.push_back(3'd1);
    do_ack(1'b1);
    check_vec("l1_vec_b");
    irq_in = '0;
    do_eoi();
    tick(3);
    check("l1_int_done", 32'(INT), 32'd0);
    check("l1_pend_done", 32'(pending), 32'h00);

    // NMI stays edge-triggered.
    nmi_in = 1'b1;
    tick(4);
    check("l2_nmi", 32'(NMI), 32'd1);
    do_ack(1'b0);
    check("l2_state", 32'(fsm_state), 32'd2);
    do_eoi();
    tick(3);
    check("l2_nmi_once", 32'(NMI), 32'd0);
    nmi_in = 1'b0;

    // Reset during service of a held line.
    irq_in = 8'h04;
    tick(4);
    do_ack(1'b1);
    check("l3_isv", 32'(in_service), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("l3_rst");
    irq_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
